hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ID-stage hazard control: load-use and mult/div HI/LO interlocks, taken-branch flush,
// plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instructionID,
  input  logic [31:0]      instructionEX,
  input  logic             EXMemRead,
  input  logic [4:0]       EXwriteReg,
  input  logic             branchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [31:0]      instructionIDstall,
  output logic             ctrlBubble,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCycles
);

  localparam logic [3:0]       MdLat  = 4'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  function automatic logic f_uses_rt(input logic [31:0] instr);
    return instr[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
  endfunction

  function automatic logic f_is_md(input logic [31:0] instr);
    return (instr[31:26] == 6'h00) && (instr[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic f_is_hilo(input logic [31:0] instr);
    return (instr[31:26] == 6'h00) && (instr[5:0] inside {6'h10, 6'h12});
  endfunction

  logic [3:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_id_valid;
  logic w_load_use;
  logic w_ex_md;
  logic w_md_busy;
  logic w_md_haz;
  logic w_stall;

  always_comb begin
    w_id_valid = (instructionID != 32'd0);
    w_load_use = EXMemRead && (EXwriteReg != 5'd0) && w_id_valid &&
                 ((EXwriteReg == instructionID[25:21]) ||
                  (f_uses_rt(instructionID) && (EXwriteReg == instructionID[20:16])));
    w_ex_md    = f_is_md(instructionEX) && (instructionEX != 32'd0);
    w_md_busy  = (r_md_cnt != 4'd0) || w_ex_md;
    // Any HI/LO reader or new mult/div waits so results never reorder or overlap.
    w_md_haz   = w_md_busy && w_id_valid &&
                 (f_is_hilo(instructionID) || f_is_md(instructionID));
    w_stall    = (w_load_use || w_md_haz) && !branchTaken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt       <= 4'd0;
      r_stall_cycles <= '0;
    end else begin
      if (w_ex_md) begin
        r_md_cnt <= MdLat;
      end else if (r_md_cnt != 4'd0) begin
        r_md_cnt <= r_md_cnt - 4'd1;
      end
      if (w_stall && (r_stall_cycles != CntMax)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  always_comb begin
    PCWrite            = 1'b1;
    IFIDWrite          = 1'b1;
    IFIDFlush          = 1'b0;
    ctrlBubble         = 1'b0;
    instructionIDstall = instructionID;
    if (!rst_n) begin
      PCWrite            = 1'b0;
      IFIDWrite          = 1'b0;
      ctrlBubble         = 1'b1;
      instructionIDstall = 32'd0;
    end else if (branchTaken) begin
      IFIDFlush          = 1'b1;
      ctrlBubble         = 1'b1;
      instructionIDstall = 32'd0;
    end else if (w_stall) begin
      PCWrite            = 1'b0;
      IFIDWrite          = 1'b0;
      ctrlBubble         = 1'b1;
      instructionIDstall = 32'd0;
    end
  end

  assign mdBusy      = rst_n && w_md_busy;
  assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks plus randomized traffic against a
// time-stamp based reference model, checked every negedge on two counter widths.
module tb_hazard_ctrl;

  localparam int unsigned MDL = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] instructionID;
  logic [31:0] instructionEX;
  logic        EXMemRead;
  logic [4:0]  EXwriteReg;
  logic        branchTaken;

  logic        pc_w, ifid_w, ifid_f, bub, busy;
  logic [31:0] id_stall;
  logic [15:0] cnt16;
  logic        pc_w4, ifid_w4, ifid_f4, bub4, busy4;
  logic [31:0] id_stall4;
  logic [3:0]  cnt4;

  hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instructionID(instructionID), .instructionEX(instructionEX),
    .EXMemRead(EXMemRead), .EXwriteReg(EXwriteReg), .branchTaken(branchTaken),
    .PCWrite(pc_w), .IFIDWrite(ifid_w), .IFIDFlush(ifid_f), .instructionIDstall(id_stall),
    .ctrlBubble(bub), .mdBusy(busy), .stallCycles(cnt16)
  );

  hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instructionID(instructionID), .instructionEX(instructionEX),
    .EXMemRead(EXMemRead), .EXwriteReg(EXwriteReg), .branchTaken(branchTaken),
    .PCWrite(pc_w4), .IFIDWrite(ifid_w4), .IFIDFlush(ifid_f4), .instructionIDstall(id_stall4),
    .ctrlBubble(bub4), .mdBusy(busy4), .stallCycles(cnt4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mult/div busy window is tracked by the cycle stamp of the last
  // mult/div seen in EX; the stall count is kept unbounded and clamped on compare.
  int cyc = 0;
  int last_md = 0;
  bit have_md = 0;
  int n_stall = 0;

  function automatic bit m_uses_rt(input logic [31:0] i);
    int op = int'(i[31:26]);
    return op == 0 || op == 4 || op == 5 || op == 'h2B;
  endfunction

  function automatic bit m_is_md(input logic [31:0] i);
    int fn = int'(i[5:0]);
    return i[31:26] == 0 && fn >= 'h18 && fn <= 'h1B;
  endfunction

  function automatic bit m_is_hilo(input logic [31:0] i);
    return i[31:26] == 0 && (i[5:0] == 'h10 || i[5:0] == 'h12);
  endfunction

  function automatic int clampc(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  always @(negedge clk) begin
    bit ld, exmd, bsy, mdh, st;
    logic [31:0] e_id;
    bit e_pc, e_fl, e_bub;
    if (!rst_n) begin
      have_md = 0;
      n_stall = 0;
      e_pc = 0; e_fl = 0; e_bub = 1; e_id = 0; bsy = 0; st = 0; exmd = 0;
    end else begin
      ld   = EXMemRead && EXwriteReg != 0 && instructionID != 0 &&
             (EXwriteReg == instructionID[25:21] ||
              (m_uses_rt(instructionID) && EXwriteReg == instructionID[20:16]));
      exmd = m_is_md(instructionEX) && instructionEX != 0;
      bsy  = exmd || (have_md && (cyc - last_md) <= int'(MDL));
      mdh  = bsy && instructionID != 0 && (m_is_hilo(instructionID) || m_is_md(instructionID));
      st   = (ld || mdh) && !branchTaken;
      e_pc  = !st;
      e_fl  = branchTaken;
      e_bub = st || branchTaken;
      e_id  = e_bub ? 32'd0 : instructionID;
    end
    check("PCWrite",  {31'd0, pc_w},   {31'd0, e_pc});
    check("IFIDWrite", {31'd0, ifid_w}, {31'd0, e_pc});
    check("IFIDFlush", {31'd0, ifid_f}, {31'd0, e_fl});
    check("ctrlBubble", {31'd0, bub},  {31'd0, e_bub});
    check("instructionIDstall", id_stall, e_id);
    check("mdBusy",   {31'd0, busy},   {31'd0, bsy});
    check("stallCycles16", {16'd0, cnt16}, 32'(clampc(n_stall, 16)));
    check("stallCycles4",  {28'd0, cnt4},  32'(clampc(n_stall, 4)));
    if (rst_n) begin
      if (exmd) begin
        have_md = 1;
        last_md = cyc;
      end
      if (st) n_stall++;
      cyc++;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic mr,
                       input logic [4:0] wr, input logic br);
    instructionID = id;
    instructionEX = ex;
    EXMemRead     = mr;
    EXwriteReg    = wr;
    branchTaken   = br;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      2: return {6'h23, rs, rt, 16'h0004};
      3: return {6'h2B, rs, rt, 16'h0008};
      4: return {6'h04, rs, rt, 16'h0010};
      5: return {6'h05, rs, rt, 16'hFFF0};
      6: return {6'h00, rs, rt, 10'd0, 6'(6'h18 + 6'($urandom_range(0, 3)))};
      7: return {16'd0, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12};
      8: return {6'h00, rs, 15'd0, 6'h11};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] LW8  = {6'h23, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] ADD  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] MULT = {6'h00, 5'd4, 5'd5, 10'd0, 6'h18};
  localparam logic [31:0] MFHI = {16'd0, 5'd2, 5'd0, 6'h10};

  initial begin
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #2;
    check("rst_PCWrite", {31'd0, pc_w}, 32'd0);
    check("rst_ctrlBubble", {31'd0, bub}, 32'd1);
    check("rst_stallCycles", {16'd0, cnt16}, 32'd0);
    next();
    next();
    rst_n = 1'b1;

    // Load-use: exactly one stall cycle.
    next();
    drive(ADD, LW8, 1'b1, 5'd8, 1'b0);
    #3;
    check("lu_PCWrite", {31'd0, pc_w}, 32'd0);
    check("lu_idstall", id_stall, 32'd0);
    next();
    drive(ADD, 32'd0, 1'b0, 5'd0, 1'b0);
    #3;
    check("lu_advance", id_stall, ADD);
    check("lu_count", {16'd0, cnt16}, 32'd1);

    // No false hazards: $0 destination, and rt of a load not a source.
    next();
    drive(ADD0, LW8, 1'b1, 5'd0, 1'b0);
    #3;
    check("nf_zero_reg", {31'd0, pc_w}, 32'd1);
    next();
    drive(LW8, LW8, 1'b1, 5'd8, 1'b0);
    #3;
    check("nf_rt_ignored", {31'd0, pc_w}, 32'd1);

    // Mult in EX with mfhi behind it: 5 stall cycles then issue.
    next();
    drive(MFHI, MULT, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #3;
      check("md_stall", {31'd0, pc_w}, 32'd0);
      check("md_busy", {31'd0, busy}, 32'd1);
      next();
      drive(MFHI, 32'd0, 1'b0, 5'd0, 1'b0);
    end
    #3;
    check("md_issue", id_stall, MFHI);
    check("md_idle", {31'd0, busy}, 32'd0);
    check("md_count", {16'd0, cnt16}, 32'd6);

    // Branch beats a load-use hazard and does not count as a stall.
    next();
    drive(ADD, LW8, 1'b1, 5'd8, 1'b1);
    #3;
    check("br_flush", {31'd0, ifid_f}, 32'd1);
    check("br_PCWrite", {31'd0, pc_w}, 32'd1);
    check("br_bubble", {31'd0, bub}, 32'd1);
    next();
    drive(32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #3;
    check("br_count", {16'd0, cnt16}, 32'd6);

    // Saturation of the narrow counter.
    for (int k = 0; k < 20; k++) begin
      next();
      drive(ADD, LW8, 1'b1, 5'd8, 1'b0);
    end
    next();
    drive(32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #3;
    check("sat_cnt4", {28'd0, cnt4}, 32'd15);
    check("sat_cnt16", {16'd0, cnt16}, 32'd26);

    // Async reset during a busy window, then a fresh mfhi must not stall.
    next();
    drive(32'd0, MULT, 1'b0, 5'd0, 1'b0);
    next();
    drive(32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("ar_busy_before", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_PCWrite", {31'd0, pc_w}, 32'd0);
    check("ar_bubble", {31'd0, bub}, 32'd1);
    check("ar_count", {16'd0, cnt16}, 32'd0);
    next();
    rst_n = 1'b1;
    drive(MFHI, 32'd0, 1'b0, 5'd0, 1'b0);
    #3;
    check("ar_mfhi_issue", id_stall, MFHI);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      next();
      drive(rand_instr(), rand_instr(), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
    end
    next();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
